// File: rtl/cache_mem_responder_if.sv
// cache_mem_responder_if
// Line-level memory bus between a cache (master) and its backing memory (slave).
//   mem_read  : line read request, level, held by the master until mem_ready
//   mem_write : line write request, level, held by the master until mem_ready
//   mem_addr  : 28-bit line address
//   mem_wdata : 128-bit write line
//   mem_rdata : 128-bit read line, returned by the slave
//   mem_ready : one-cycle completion pulse from the slave
//   proto_err : sticky flag, both requests seen high when a request was accepted
interface cache_mem_responder_if;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         proto_err;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready, proto_err
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready, proto_err
    );
endinterface

// File: rtl/cache_mem_responder.sv
// cache_mem_responder
// Fixed-latency main-memory model for the cache's 128-bit line interface.
// Accepts one line read or write at a time and answers LATENCY cycles later
// with a one-cycle mem_ready pulse, then spends one recovery cycle ignoring
// the initiator's stale request before it can accept again.
//   clk        : single clock, rising edge
//   proc_reset : synchronous active-high reset; clears the array and aborts
//                any transaction in flight
//   bus        : slave side of cache_mem_responder_if (requests in, rdata /
//                ready / proto_err out, all outputs registered)
module cache_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 8
) (
    input logic                  clk,
    input logic                  proc_reset,
    cache_mem_responder_if.slave bus
);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam int LINES = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, BUSY, READY, RECOVER} state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   count, next_count;
    logic               accept;

    // Latched request, captured at accept and used for the rest of the
    // transaction so the initiator's later input changes are ignored.
    logic               op_write;
    logic [ADDR_W-1:0]  line_idx;
    logic [127:0]       wdata_q;

    // Request as seen on the completion edge; with LATENCY=1 that edge is the
    // accept edge itself, so the live inputs must be used instead of the latch.
    logic               cur_write;
    logic [ADDR_W-1:0]  cur_idx;
    logic [127:0]       cur_wdata;

    logic [127:0]       mem [LINES];

    always_comb begin
        // NOTE: every signal driven here gets a default before the case, so no
        // path leaves it unassigned and no latch is inferred.
        next_state = state;
        next_count = count;
        accept     = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.mem_write || bus.mem_read) begin
                    accept     = 1'b1;
                    next_count = CNT_W'(LATENCY - 1);
                    next_state = (LATENCY == 1) ? READY : BUSY;
                end
            end
            BUSY: begin
                // Counter holds LATENCY-1 after accept; leaving on the edge where
                // it reaches zero puts mem_ready in the cycle after A+LATENCY-1.
                if (count <= CNT_W'(1)) begin
                    next_count = '0;
                    next_state = READY;
                end else begin
                    next_count = count - CNT_W'(1);
                end
            end
            READY:   next_state = RECOVER;
            RECOVER: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cur_write = op_write;
        cur_idx   = line_idx;
        cur_wdata = wdata_q;
        if (accept) begin
            // Write wins when both requests are high.
            cur_write = bus.mem_write;
            cur_idx   = bus.mem_addr[ADDR_W-1:0];
            cur_wdata = bus.mem_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= next_state;
            count <= next_count;
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
            bus.proto_err <= 1'b0;
            op_write      <= 1'b0;
            line_idx      <= '0;
            wdata_q       <= '0;
            // NOTE: the array is cleared by reset, which makes it a register file
            // rather than an inferable RAM; acceptable for a simulation memory.
            for (int i = 0; i < LINES; i++) begin
                mem[i] <= '0;
            end
        end else begin
            bus.mem_ready <= (next_state == READY);

            if (accept) begin
                op_write <= bus.mem_write;
                line_idx <= bus.mem_addr[ADDR_W-1:0];
                wdata_q  <= bus.mem_wdata;
                if (bus.mem_write && bus.mem_read) begin
                    bus.proto_err <= 1'b1;
                end
            end

            // Commit or fetch on the edge entering READY, so a write is in the
            // array before any later request can be accepted.
            if (next_state == READY) begin
                if (cur_write) begin
                    mem[cur_idx] <= cur_wdata;
                end else begin
                    bus.mem_rdata <= mem[cur_idx];
                end
            end
        end
    end
endmodule

// File: doc/cache_mem_responder.md
# cache_mem_responder

Behavioural-synthesizable memory responder for the cache's 128-bit line interface. It sits on the memory side of the cache, accepts one line read or line write at a time on the level-held `mem_read`/`mem_write` request, and answers after a fixed, parameterized latency with a one-cycle `mem_ready` pulse. It serves as the slow main memory in cache bring-up and regression benches, and as the memory stub in system simulation.

## Interface
- `ADDR_W`, 8: number of line-address bits decoded; the array holds 2^ADDR_W lines of 128 bits.
- `LATENCY`, 8: cycles from request acceptance to `mem_ready`; legal range 1..255.
- `clk` input 1: single clock, rising edge.
- `proc_reset` input 1: reset, synchronous, active-high.
- `mem_read` input 1: line read request, level, held until `mem_ready`.
- `mem_write` input 1: line write request, level, held until `mem_ready`.
- `mem_addr` input 28: line address; bits [ADDR_W-1:0] select the line, upper bits ignored (aliasing).
- `mem_wdata` input 128: write line data.
- `mem_rdata` output 128: read line data, registered.
- `mem_ready` output 1: one-cycle completion pulse, registered.
- `proto_err` output 1: sticky flag, set when `mem_read` and `mem_write` are both high in an accepting cycle.

## Operation
- States: IDLE, BUSY, READY, RECOVER.
- IDLE: on an edge with `mem_write` or `mem_read` high, accept: latch op, line index, `mem_wdata`; load counter with LATENCY-1; go to BUSY, or straight to READY if LATENCY=1.
- Both requests high at accept: write wins, read dropped, `proto_err` set (cleared only by reset).
- BUSY: decrement counter each cycle; at zero go to READY. Request inputs, `mem_addr`, `mem_wdata` ignored while BUSY (latched copies used).
- Entering READY: `mem_ready` registered high for exactly one cycle. Read: `mem_rdata` loaded with the addressed line on the same edge. Write: latched data committed to the array on the same edge.
- READY -> RECOVER unconditionally. RECOVER ignores requests for one cycle (the initiator's registered request is still stale there), then -> IDLE.
- A request high in RECOVER is not accepted; if still high in IDLE the next cycle it is accepted then. Back-to-back requests (write-back then refill) therefore each cost LATENCY+2 cycles minimum.
- `mem_rdata` holds its last read value until the next read completes; writes do not change it.
- Write then read of the same line returns the written data (commit precedes any later accept).

## Timing
- Reset (edge with `proc_reset` high): state IDLE, counter 0, `mem_ready`=0, `mem_rdata`=0, `proto_err`=0, all array lines cleared to 0. Reset mid-transaction aborts it: no write commit, no `mem_ready` pulse.
- Accept edge = A. `mem_ready` high in the cycle after edge A+LATENCY-1, i.e. sampled high by the initiator at edge A+LATENCY; low everywhere else.
- Earliest next accept edge = A+LATENCY+2.
- Counter width ceil(log2(LATENCY+1)); never wraps below 0.
- No combinational path from inputs to outputs.

## Test plan
- Reset then idle 20 cycles with no request -> `mem_ready`=0, `mem_rdata`=0, `proto_err`=0 throughout.
- LATENCY=8: write addr 0x05, data 0x0123…CDEF held until ready -> `mem_ready` one cycle at A+8; then read 0x05 -> `mem_rdata`=0x0123…CDEF with `mem_ready` at its A+8.
- Aliasing, ADDR_W=8: write 0x0000105 with 0xAA…AA, read 0x0000005 -> returns 0xAA…AA.
- Cache-style write-back then refill: `mem_write` drops and `mem_read` rises the cycle after ready -> read accepted in IDLE exactly 2 cycles after the ready cycle, completes LATENCY later, no double write.
- Both `mem_read` and `mem_write` high at accept -> write performed, no read data change, `proto_err`=1 until reset.
- `proc_reset` pulsed at cycle A+3 of a write with LATENCY=8 -> no `mem_ready`; subsequent read of that line returns 0.
